// File: rtl/udma_i2c_cmd_arbiter.sv
// Per-transaction arbiter in front of the I2C command-stream controller.
// Tracks command framing so operand and data bytes never release the grant.
module udma_i2c_cmd_arbiter #(
  parameter int N_REQ = 2,
  parameter int OW    = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             sw_rst_i,
  input  logic [N_REQ*8-1:0] req_data_i,
  input  logic [N_REQ-1:0] req_valid_i,
  output logic [N_REQ-1:0] req_ready_o,
  output logic [7:0]       data_tx_o,
  output logic             data_tx_valid_o,
  input  logic             data_tx_ready_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [OW-1:0]    owner_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RPT,
    ST_SKIP,
    ST_OPND
  } state_e;

  localparam logic [3:0] C_STOP = 4'h2;
  localparam logic [3:0] C_WR   = 4'h8;
  localparam logic [3:0] C_EOT  = 4'h9;
  localparam logic [3:0] C_WAIT = 4'hA;
  localparam logic [3:0] C_RPT  = 4'hC;
  localparam logic [3:0] C_CFG  = 4'hE;

  state_e          state;
  logic [OW-1:0]   rr_ptr;
  logic [7:0]      opcnt;
  logic [7:0]      rpt;
  logic            rpt_pend;

  logic [OW-1:0]   pick;
  logic            pick_vld;
  logic [OW:0]     sum;
  logic [OW-1:0]   nxt_ptr;
  logic            beat;
  logic [3:0]      code;

  assign data_tx_o       = req_data_i[{owner_o, 3'b000} +: 8];
  assign data_tx_valid_o = (state != ST_IDLE) & ~sw_rst_i
                         & req_valid_i[owner_o];
  assign beat            = data_tx_valid_o & data_tx_ready_i;
  assign code            = data_tx_o[7:4];
  assign nxt_ptr         = (owner_o == OW'(N_REQ-1)) ? '0
                         : owner_o + 1'b1;

  always_comb begin
    req_ready_o = '0;
    if (sw_rst_i)
      req_ready_o = '1;
    else if (state != ST_IDLE)
      req_ready_o[owner_o] = data_tx_ready_i;
  end

  // First valid requester at/after the round-robin pointer, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (OW+1)'(i);
      if (sum >= (OW+1)'(N_REQ))
        sum = sum - (OW+1)'(N_REQ);
      if (!pick_vld && req_valid_i[sum[OW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = sum[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_IDLE;
      grant_o  <= '0;
      owner_o  <= '0;
      busy_o   <= 1'b0;
      rr_ptr   <= '0;
      opcnt    <= '0;
      rpt      <= '0;
      rpt_pend <= 1'b0;
    end else if (sw_rst_i) begin
      state    <= ST_IDLE;
      grant_o  <= '0;
      owner_o  <= '0;
      busy_o   <= 1'b0;
      rr_ptr   <= '0;
      opcnt    <= '0;
      rpt      <= '0;
      rpt_pend <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (pick_vld) begin
        owner_o <= pick;
        grant_o <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
        busy_o  <= 1'b1;
        state   <= ST_CMD;
      end
    end else if (beat) begin
      unique case (state)
        ST_CMD: begin
          if (code != C_RPT)
            rpt_pend <= 1'b0;
          unique case (1'b1)
            (code == C_STOP) || (code == C_EOT): begin
              state   <= ST_IDLE;
              grant_o <= '0;
              busy_o  <= 1'b0;
              rr_ptr  <= nxt_ptr;
            end
            code == C_WR: begin
              opcnt <= rpt_pend ? rpt : 8'd1;
              state <= ST_OPND;
            end
            code == C_WAIT: begin
              opcnt <= 8'd1;
              state <= ST_OPND;
            end
            code == C_CFG: begin
              opcnt <= 8'd2;
              state <= ST_OPND;
            end
            code == C_RPT:
              state <= ST_RPT;
            default: ;
          endcase
        end
        ST_RPT: begin
          if (data_tx_o == 8'h00) begin
            rpt_pend <= 1'b0;
            state    <= ST_SKIP;
          end else begin
            rpt      <= data_tx_o;
            rpt_pend <= 1'b1;
            state    <= ST_CMD;
          end
        end
        // The controller discards this command; pass it through undecoded.
        ST_SKIP: state <= ST_CMD;
        ST_OPND: begin
          opcnt <= opcnt - 8'd1;
          if (opcnt == 8'd1)
            state <= ST_CMD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
